// File: rtl/key_event_filter_if.sv
// key_event_filter_if: scanner-side key signals and the filtered key events.
// master drives the raw scanner inputs; slave is the filter producing events.
interface key_event_filter_if;
    logic       BSTATE;
    logic [3:0] BUTTON;
    logic       BPRESS;
    logic [3:0] KEY;
    logic       HOLD;
    logic       DOWN;

    modport master (
        output BSTATE, BUTTON,
        input  BPRESS, KEY, HOLD, DOWN
    );

    modport slave (
        input  BSTATE, BUTTON,
        output BPRESS, KEY, HOLD, DOWN
    );
endinterface

// File: rtl/key_event_filter.sv
// key_event_filter: synchronises and debounces the raw scanner key pair into one BPRESS
// per short press, a HOLD pulse per long press, a latched KEY and a debounced DOWN level.
module key_event_filter #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd60000,
    parameter logic [23:0] HOLD_CYCLES     = 24'd12000000
) (
    input logic               CLK,
    input logic               RST_N,
    key_event_filter_if.slave kif
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PRESS_DB   = 2'd1;
    localparam logic [1:0] ST_DOWN       = 2'd2;
    localparam logic [1:0] ST_RELEASE_DB = 2'd3;

    localparam logic [15:0] DB_LAST   = DEBOUNCE_CYCLES - 16'd1;
    localparam logic [23:0] HOLD_LAST = HOLD_CYCLES - 24'd1;
    localparam logic        HOLD_EN   = (HOLD_CYCLES != 24'd0);

    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] dcnt_q, dcnt_d;
    logic [23:0] hcnt_q, hcnt_d;
    logic        held_q, held_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  key_q, key_d;
    logic        bpress_q, bpress_d;
    logic        hold_q, hold_d;
    logic        down_q, down_d;

    always_comb begin
        s1_d     = kif.BSTATE;
        s2_d     = s1_q;
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        hcnt_d   = hcnt_q;
        held_d   = held_q;
        cand_d   = cand_q;
        key_d    = key_q;
        bpress_d = 1'b0;
        hold_d   = 1'b0;
        down_d   = down_q;
        case (state_q)
            ST_IDLE: begin
                if (s2_q) begin
                    state_d = ST_PRESS_DB;
                    dcnt_d  = 16'd0;
                    cand_d  = kif.BUTTON;
                end
            end
            ST_PRESS_DB: begin
                if (!s2_q) begin
                    state_d = ST_IDLE;
                end else if (dcnt_q == DB_LAST) begin
                    state_d = ST_DOWN;
                    key_d   = cand_q;
                    down_d  = 1'b1;
                    hcnt_d  = 24'd0;
                    held_d  = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 16'd1;
                end
            end
            ST_DOWN: begin
                // Saturating hold counter: a single press can never produce a second HOLD.
                hcnt_d = (&hcnt_q) ? hcnt_q : hcnt_q + 24'd1;
                if (HOLD_EN && hcnt_q == HOLD_LAST && !held_q) begin
                    hold_d = 1'b1;
                    held_d = 1'b1;
                end
                if (!s2_q) begin
                    state_d = ST_RELEASE_DB;
                    dcnt_d  = 16'd0;
                end
            end
            default: begin
                if (s2_q) begin
                    state_d = ST_DOWN;
                end else if (dcnt_q == DB_LAST) begin
                    state_d  = ST_IDLE;
                    down_d   = 1'b0;
                    bpress_d = !held_q;
                end else begin
                    dcnt_d = dcnt_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            state_q  <= ST_IDLE;
            dcnt_q   <= 16'd0;
            hcnt_q   <= 24'd0;
            held_q   <= 1'b0;
            cand_q   <= 4'd0;
            key_q    <= 4'd0;
            bpress_q <= 1'b0;
            hold_q   <= 1'b0;
            down_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            hcnt_q   <= hcnt_d;
            held_q   <= held_d;
            cand_q   <= cand_d;
            key_q    <= key_d;
            bpress_q <= bpress_d;
            hold_q   <= hold_d;
            down_q   <= down_d;
        end
    end

    assign kif.BPRESS = bpress_q;
    assign kif.KEY    = key_q;
    assign kif.HOLD   = hold_q;
    assign kif.DOWN   = down_q;

endmodule

// File: tb/tb_key_event_filter.sv
// tb_key_event_filter: directed checks of key_event_filter with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20.
module tb_key_event_filter;

    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   nb = 0;
    int   nh = 0;
    int   nboth = 0;
    int   nb0, nh0;
    logic seen;

    key_event_filter_if kif();

    key_event_filter #(
        .DEBOUNCE_CYCLES(16'd4),
        .HOLD_CYCLES    (24'd20)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .kif  (kif.slave)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (kif.BPRESS === 1'b1) nb++;
        if (kif.HOLD === 1'b1) nh++;
        if (kif.BPRESS === 1'b1 && kif.HOLD === 1'b1) nboth++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        kif.BSTATE = 1'b0;
        kif.BUTTON = 4'd0;
        #2 RST_N = 1'b0;
        tick(3);
        chk("rst_bpress", 32'(kif.BPRESS), 32'd0);
        chk("rst_key", 32'(kif.KEY), 32'd0);
        chk("rst_hold", 32'(kif.HOLD), 32'd0);
        chk("rst_down", 32'(kif.DOWN), 32'd0);
        RST_N = 1'b1;
        tick(3);

        // press glitch shorter than the debounce window
        nb0 = nb;
        kif.BUTTON = 4'd5;
        kif.BSTATE = 1'b1;
        tick(2);
        kif.BSTATE = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen |= kif.DOWN;
        end
        chk("glitch_down", 32'(seen), 32'd0);
        chk("glitch_key", 32'(kif.KEY), 32'd0);
        chk("glitch_bpress", 32'(nb - nb0), 32'd0);

        // clean press of 9
        nb0 = nb;
        nh0 = nh;
        kif.BUTTON = 4'd9;
        kif.BSTATE = 1'b1;
        tick(6);
        chk("clean_down_early", 32'(kif.DOWN), 32'd0);
        tick(1);
        chk("clean_down", 32'(kif.DOWN), 32'd1);
        chk("clean_key", 32'(kif.KEY), 32'd9);
        tick(3);
        kif.BSTATE = 1'b0;
        tick(6);
        chk("clean_bpress_early", 32'(kif.BPRESS), 32'd0);
        chk("clean_down_held", 32'(kif.DOWN), 32'd1);
        tick(1);
        chk("clean_bpress", 32'(kif.BPRESS), 32'd1);
        chk("clean_down_off", 32'(kif.DOWN), 32'd0);
        chk("clean_key_rel", 32'(kif.KEY), 32'd9);
        chk("clean_hold", 32'(kif.HOLD), 32'd0);
        tick(1);
        chk("clean_bpress_end", 32'(kif.BPRESS), 32'd0);
        tick(2);
        chk("clean_bpress_cnt", 32'(nb - nb0), 32'd1);
        chk("clean_hold_cnt", 32'(nh - nh0), 32'd0);
        tick(3);

        // release bounce after a press of 8
        nb0 = nb;
        kif.BUTTON = 4'd8;
        kif.BSTATE = 1'b1;
        tick(10);
        chk("bounce_key", 32'(kif.KEY), 32'd8);
        kif.BSTATE = 1'b0;
        tick(2);
        kif.BSTATE = 1'b1;
        tick(1);
        kif.BSTATE = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            seen |= !kif.DOWN;
        end
        chk("bounce_down_cont", 32'(seen), 32'd0);
        chk("bounce_bpress_early", 32'(kif.BPRESS), 32'd0);
        tick(1);
        chk("bounce_bpress", 32'(kif.BPRESS), 32'd1);
        chk("bounce_key_rel", 32'(kif.KEY), 32'd8);
        tick(3);
        chk("bounce_bpress_cnt", 32'(nb - nb0), 32'd1);
        chk("bounce_down_off", 32'(kif.DOWN), 32'd0);
        tick(3);

        // long press of 7
        nb0 = nb;
        nh0 = nh;
        kif.BUTTON = 4'd7;
        kif.BSTATE = 1'b1;
        tick(26);
        chk("long_hold_early", 32'(kif.HOLD), 32'd0);
        tick(1);
        chk("long_hold", 32'(kif.HOLD), 32'd1);
        chk("long_down", 32'(kif.DOWN), 32'd1);
        chk("long_bpress_at_hold", 32'(kif.BPRESS), 32'd0);
        tick(1);
        chk("long_hold_end", 32'(kif.HOLD), 32'd0);
        tick(12);
        kif.BSTATE = 1'b0;
        tick(6);
        chk("long_down_held", 32'(kif.DOWN), 32'd1);
        tick(1);
        chk("long_down_off", 32'(kif.DOWN), 32'd0);
        chk("long_no_bpress", 32'(kif.BPRESS), 32'd0);
        tick(3);
        chk("long_bpress_cnt", 32'(nb - nb0), 32'd0);
        chk("long_hold_cnt", 32'(nh - nh0), 32'd1);
        chk("long_key", 32'(kif.KEY), 32'd7);
        tick(3);

        // asynchronous reset while the key is down
        kif.BUTTON = 4'd4;
        kif.BSTATE = 1'b1;
        tick(10);
        chk("rstmid_down", 32'(kif.DOWN), 32'd1);
        chk("rstmid_key", 32'(kif.KEY), 32'd4);
        #2 RST_N = 1'b0;
        #1;
        chk("rstmid_async_down", 32'(kif.DOWN), 32'd0);
        chk("rstmid_async_key", 32'(kif.KEY), 32'd0);
        chk("rstmid_async_bpress", 32'(kif.BPRESS), 32'd0);
        chk("rstmid_async_hold", 32'(kif.HOLD), 32'd0);
        tick(2);
        RST_N = 1'b1;
        tick(1);
        kif.BSTATE = 1'b0;
        nb0 = nb;
        tick(20);
        chk("rstmid_no_bpress", 32'(nb - nb0), 32'd0);
        chk("rstmid_down_after", 32'(kif.DOWN), 32'd0);
        chk("rstmid_key_after", 32'(kif.KEY), 32'd0);

        // code change while the key is down
        nb0 = nb;
        kif.BUTTON = 4'd9;
        kif.BSTATE = 1'b1;
        tick(10);
        kif.BUTTON = 4'd3;
        tick(3);
        kif.BSTATE = 1'b0;
        tick(7);
        chk("change_bpress", 32'(kif.BPRESS), 32'd1);
        chk("change_key", 32'(kif.KEY), 32'd9);
        tick(2);
        chk("change_bpress_cnt", 32'(nb - nb0), 32'd1);
        chk("no_overlap", 32'(nboth), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
